// File: rtl/oai_mult.sv
// rtl/oai_mult.sv - bit-parallel OR-AND-INVERT partial-product cell with registered copy
//
// Ports:
//   clk       rising-edge clock for the registered path
//   rst       asynchronous active-high reset of the registered path
//   a, b      WIDTH-bit operands
//   c, d      1-bit controls broadcast across the word (force (a|c) / (b|d) to 1)
//   in_valid  qualifies a/b/c/d for capture into e_q
//   e         combinational result ~((a|{WIDTH{c}}) & (b|{WIDTH{d}}))
//   e_q       registered copy of e, updated only on in_valid
//   out_valid e_q holds a result captured on the previous edge

module oai_mult #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             d,
    input  logic             in_valid,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] e_q,
    output logic             out_valid
);

    // Bits are independent: c and d act as per-word force/mask controls.
    //   c=0,d=0 -> NAND(a,b); c=0,d=1 -> ~a; c=1,d=0 -> ~b; c=1,d=1 -> 0
    logic [WIDTH-1:0] a_term;
    logic [WIDTH-1:0] b_term;

    assign a_term = a | {WIDTH{c}};
    assign b_term = b | {WIDTH{d}};
    assign e      = ~(a_term & b_term);

    // e_q keeps its last captured value across idle cycles; out_valid is a
    // one-cycle strobe per capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                e_q <= e;
            end
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_oai_mult.sv
// tb/tb_oai_mult.sv - self-checking bench for oai_mult at WIDTH 12, 1 and 32

module tb_oai_mult;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // WIDTH=12 instance
    logic [11:0] a = '0, b = '0;
    logic        c = 1'b0, d = 1'b0, in_valid = 1'b0;
    logic [11:0] e, e_q;
    logic        out_valid;

    // WIDTH=1 instance
    logic [0:0]  a1 = '0, b1 = '0;
    logic        c1 = 1'b0, d1 = 1'b0, in_valid1 = 1'b0;
    logic [0:0]  e1, e_q1;
    logic        out_valid1;

    // WIDTH=32 instance
    logic [31:0] a32 = '0, b32 = '0;
    logic        c32 = 1'b0, d32 = 1'b0, in_valid32 = 1'b0;
    logic [31:0] e32, e_q32;
    logic        out_valid32;

    int checks = 0;
    int errors = 0;

    // expected registered state per instance
    logic [11:0] exp_q   = '0;
    logic        exp_v   = 1'b0;
    logic [0:0]  exp_q1  = '0;
    logic        exp_v1  = 1'b0;
    logic [31:0] exp_q32 = '0;
    logic        exp_v32 = 1'b0;

    oai_mult #(.WIDTH(12)) u12 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
        .e(e), .e_q(e_q), .out_valid(out_valid)
    );

    oai_mult #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .in_valid(in_valid1),
        .e(e1), .e_q(e_q1), .out_valid(out_valid1)
    );

    oai_mult #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .c(c32), .d(d32), .in_valid(in_valid32),
        .e(e32), .e_q(e_q32), .out_valid(out_valid32)
    );

    always #5 clk = ~clk;

    // Mode-level reference: the control pair selects one of four functions.
    function automatic logic [31:0] ref_oai(input logic [31:0] x, input logic [31:0] y,
                                            input logic cc, input logic dd, input int w);
        logic [31:0] r;
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ({cc, dd})
            2'b00:   r = ~(x & y);
            2'b01:   r = ~x;
            2'b10:   r = ~y;
            default: r = 32'd0;
        endcase
        return r & mask;
    endfunction

    // Advance one rising edge, updating the expected registered state from
    // the inputs presented at that edge, then settle 1 time unit.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (in_valid)   exp_q   = 12'(ref_oai({20'd0, a}, {20'd0, b}, c, d, 12));
            if (in_valid1)  exp_q1  = 1'(ref_oai({31'd0, a1}, {31'd0, b1}, c1, d1, 1));
            if (in_valid32) exp_q32 = ref_oai(a32, b32, c32, d32, 32);
            exp_v   = in_valid;
            exp_v1  = in_valid1;
            exp_v32 = in_valid32;
        end
        #1;
    endtask

    task automatic drive12(input logic [11:0] aa, input logic [11:0] bb,
                           input logic cc, input logic dd, input logic iv);
        @(negedge clk);
        a = aa; b = bb; c = cc; d = dd; in_valid = iv;
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        if (e_q !== 12'h000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: e_q=%h out_valid=%b, want e_q=000 out_valid=0", e_q, out_valid);
        end
        checks++;
        in_valid = 1'b1; in_valid1 = 1'b1; in_valid32 = 1'b1;
        repeat (2) step();
        if (e_q !== 12'h000 || out_valid !== 1'b0 || e_q1 !== 1'b0 || e_q32 !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: e_q=%h out_valid=%b e_q1=%b e_q32=%h, want all 0",
                     e_q, out_valid, e_q1, e_q32);
        end
        checks++;
        @(negedge clk);
        in_valid = 1'b0; in_valid1 = 1'b0; in_valid32 = 1'b0;
        rst = 1'b0;
        exp_q = '0; exp_v = 1'b0; exp_q1 = '0; exp_v1 = 1'b0; exp_q32 = '0; exp_v32 = 1'b0;
    endtask

    task automatic test_nand();
        logic [11:0] ta [6] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hF0F, 12'hA5A};
        logic [11:0] tb [6] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h0F0, 12'h5A5};
        logic [11:0] te [6] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        for (int i = 0; i < 6; i++) begin
            drive12(ta[i], tb[i], 1'b0, 1'b0, 1'b0);
            if (e !== te[i]) begin
                errors++;
                $display("FAIL nand[%0d]: a=%h b=%h e=%h, want %h", i, ta[i], tb[i], e, te[i]);
            end
            checks++;
        end
    endtask

    task automatic test_overrides();
        logic [11:0] tv [4] = '{12'hFFF, 12'h000, 12'hF0F, 12'hA5A};
        logic [11:0] te [4] = '{12'h000, 12'hFFF, 12'h0F0, 12'h5A5};
        for (int i = 0; i < 4; i++) begin
            drive12(tv[i], 12'hFFF, 1'b0, 1'b1, 1'b0);
            if (e !== te[i]) begin
                errors++;
                $display("FAIL not_a[%0d]: a=%h e=%h, want %h", i, tv[i], e, te[i]);
            end
            checks++;
            drive12(12'hFFF, tv[i], 1'b1, 1'b0, 1'b0);
            if (e !== te[i]) begin
                errors++;
                $display("FAIL not_b[%0d]: b=%h e=%h, want %h", i, tv[i], e, te[i]);
            end
            checks++;
        end
    endtask

    task automatic test_zero_mode();
        logic [11:0] ta [3] = '{12'hFFF, 12'h000, 12'hA5A};
        logic [11:0] tb [3] = '{12'hFFF, 12'h000, 12'h5A5};
        for (int i = 0; i < 3; i++) begin
            drive12(ta[i], tb[i], 1'b1, 1'b1, 1'b0);
            if (e !== 12'h000) begin
                errors++;
                $display("FAIL zero_mode[%0d]: e=%h, want 000", i, e);
            end
            checks++;
        end
    endtask

    task automatic test_registered();
        drive12(12'hA5A, 12'h5A5, 1'b0, 1'b0, 1'b1);
        step();
        if (e_q !== 12'hFFF || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg_capture: e_q=%h out_valid=%b, want FFF 1", e_q, out_valid);
        end
        checks++;
        drive12(12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0);
        step();
        if (e_q !== 12'hFFF || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reg_hold: e_q=%h out_valid=%b, want FFF 0", e_q, out_valid);
        end
        checks++;
        // Reset between edges clears immediately; e stays live meanwhile.
        drive12(12'h0F0, 12'hFFF, 1'b0, 1'b0, 1'b1);
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (e_q !== 12'h000 || out_valid !== 1'b0 || e !== 12'hF0F) begin
            errors++;
            $display("FAIL mid_reset: e_q=%h out_valid=%b e=%h, want 000 0 F0F", e_q, out_valid, e);
        end
        checks++;
        step();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q = '0; exp_v = 1'b0;
        step();
        if (e_q !== 12'h000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: e_q=%h out_valid=%b, want 000 0", e_q, out_valid);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive12(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            step();
            if (e_q !== exp_q || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: e_q=%h out_valid=%b, want %h 1", i, e_q, out_valid, exp_q);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [11:0] want;
        for (int i = 0; i < 1200; i++) begin
            drive12(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            want = 12'(ref_oai({20'd0, a}, {20'd0, b}, c, d, 12));
            if (e !== want) begin
                errors++;
                $display("FAIL rand_e[%0d]: a=%h b=%h c=%b d=%b e=%h, want %h", i, a, b, c, d, e, want);
            end
            checks++;
            step();
            if (e_q !== exp_q || out_valid !== exp_v) begin
                errors++;
                $display("FAIL rand_q[%0d]: e_q=%h out_valid=%b, want %h %b", i, e_q, out_valid, exp_q, exp_v);
            end
            checks++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_width1();
        logic [0:0] want;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a1 = 1'(i); b1 = 1'(i >> 1); c1 = 1'(i >> 2); d1 = 1'(i >> 3);
            in_valid1 = 1'b1;
            #1;
            want = 1'(ref_oai({31'd0, a1}, {31'd0, b1}, c1, d1, 1));
            if (e1 !== want) begin
                errors++;
                $display("FAIL w1_e[%0d]: e=%b, want %b", i, e1, want);
            end
            checks++;
            step();
            if (e_q1 !== exp_q1 || out_valid1 !== exp_v1) begin
                errors++;
                $display("FAIL w1_q[%0d]: e_q=%b out_valid=%b, want %b %b", i, e_q1, out_valid1, exp_q1, exp_v1);
            end
            checks++;
        end
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic test_width32();
        logic [31:0] pat [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hAAAA_AAAA, 32'h5555_5555};
        logic [31:0] want;
        for (int cd = 0; cd < 4; cd++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    a32 = pat[i]; b32 = pat[j]; c32 = 1'(cd >> 1); d32 = 1'(cd);
                    in_valid32 = 1'(i == j);
                    #1;
                    want = ref_oai(a32, b32, c32, d32, 32);
                    if (e32 !== want) begin
                        errors++;
                        $display("FAIL w32_e[cd=%0d,%0d,%0d]: e=%h, want %h", cd, i, j, e32, want);
                    end
                    checks++;
                    step();
                    if (e_q32 !== exp_q32 || out_valid32 !== exp_v32) begin
                        errors++;
                        $display("FAIL w32_q[cd=%0d,%0d,%0d]: e_q=%h out_valid=%b, want %h %b",
                                 cd, i, j, e_q32, out_valid32, exp_q32, exp_v32);
                    end
                    checks++;
                end
            end
        end
        @(negedge clk);
        in_valid32 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nand();
        test_overrides();
        test_zero_mode();
        test_registered();
        test_back_to_back();
        test_random();
        test_width1();
        test_width32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oai_mult.md
Name: oai_mult

Overview:
- Bit-parallel OR-AND-INVERT partial-product cell for the DCIM macro.
- Per bit i: e[i] = ~((a[i] | c) & (b[i] | d)). The 1-bit controls c and d are broadcast across the word and act as force/mask inputs.
- Control modes:
  - c=0, d=0: NAND(a, b), the inverted 1-bit product.
  - c=0, d=1: ~a.
  - c=1, d=0: ~b.
  - c=1, d=1: all zeros.
- Provides a combinational result for the adder tree, plus a registered copy with a valid flag for pipelined integration.

Parameters:
- WIDTH, 12, operand/result width in bits (legal range >=1).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  control: forces the (a|c) term to 1 for all bits.
- d  input  1  control: forces the (b|d) term to 1 for all bits.
- in_valid  input  1  qualifies a/b/c/d for capture into the registered path.
- e  output  WIDTH  combinational result ~((a|{WIDTH{c}}) & (b|{WIDTH{d}})).
- e_q  output  WIDTH  registered result.
- out_valid  output  1  e_q holds a freshly captured result.

Behaviour:
- Combinational output e:
  - Purely combinational, zero latency, independent of clk and rst; valid while rst is asserted.
  - c is replicated to WIDTH bits and ORed with a; d is replicated and ORed with b.
  - The two OR terms are ANDed bitwise, then inverted. No carries; bits are independent.
- Reset: rst=1 asynchronously forces e_q=0 and out_valid=0 with no clock edge required. These values hold while rst is high.
- Registered path, at each rising clk with rst=0:
  - in_valid=1: e_q <= the current combinational value of e; out_valid <= 1.
  - in_valid=0: e_q holds its previous value; out_valid <= 0.
- Latency: 1 cycle from an in_valid=1 sample to out_valid=1 with the matching e_q.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- rst asserted mid-stream: the in-flight result is discarded and out_valid is 0 immediately.
  - After rst deasserts, the first capture happens on the first rising edge with in_valid=1.
- X-propagation: no special handling is required.
- Width rule: every output bit depends only on a[i], b[i], c and d. No sign or overflow semantics.

Test Plan:
- c=0, d=0 (NAND mode), checked on e:
  - a=FFF, b=FFF -> e=000.
  - a=FFF, b=000 -> FFF.
  - a=000, b=FFF -> FFF.
  - a=000, b=000 -> FFF.
  - a=F0F, b=0F0 -> FFF.
  - a=A5A, b=5A5 -> FFF.
- Control overrides, checked on e:
  - c=0, d=1 (~a mode): a=FFF -> 000; a=000 -> FFF; a=F0F -> 0F0; a=A5A -> 5A5, with b=FFF throughout.
  - c=1, d=0 (~b mode): b=FFF -> 000; b=000 -> FFF; b=F0F -> 0F0; b=A5A -> 5A5, with a=FFF throughout.
- c=1, d=1 -> e=000 for (FFF,FFF), (000,000) and (A5A,5A5).
- Registered path:
  - Hold rst=1 -> e_q=000 and out_valid=0 with no clock edges.
  - Release rst, then apply in_valid=1 with a=A5A, b=5A5, c=0, d=0 -> after 1 edge, e_q=FFF and out_valid=1.
  - Next cycle in_valid=0 -> out_valid=0 and e_q stays FFF.
  - Assert rst between edges -> e_q=000 immediately.
- Random: at least 1000 vectors of random a, b, c, d and in_valid.
  - Compare e against ~((a|{12{c}})&(b|{12{d}})).
  - Compare e_q/out_valid against a 1-cycle delayed reference model.
- WIDTH=1 and WIDTH=32 builds: exhaustive check for WIDTH=1; for WIDTH=32, apply the all-ones, all-zeros and alternating patterns under all four c/d combinations.
